// File: rtl/pc_ctrl.sv
// Fetch-stage program-counter controller: picks the next fetch address from
// sequential, branch, jump or jr, honouring a single MIPS delay slot.
module pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic        id_fire,
    input  logic [31:0] id_pc,
    input  logic        is_branch,
    input  logic        branch_in,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] pc_out,
    output logic        pc_req,
    output logic        redirect_pending
);

    typedef enum logic {
        RUN,
        PENDING
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pending_target_q, pending_target_d;
    logic        pc_req_q;

    logic        advance;
    logic        redirect;
    logic [31:0] seq_pc;
    logic [31:0] branch_off;
    logic [31:0] target;

    assign advance    = pc_req_q & imem_ready & ~stall;
    assign redirect   = id_fire & (jr | jump | (is_branch & branch_in));
    assign seq_pc     = id_pc + 32'd4;
    assign branch_off = {{14{branch_imm[15]}}, branch_imm, 2'b00};

    // jr wins over jump, which wins over a taken branch.
    always_comb begin
        if (jr) begin
            target = jr_target;
        end else if (jump) begin
            target = {seq_pc[31:28], jump_index, 2'b00};
        end else begin
            target = seq_pc + branch_off;
        end
    end

    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        pending_target_d = pending_target_q;
        unique case (state_q)
            RUN: begin
                if (advance) begin
                    pc_d = redirect ? target : pc_q + 32'(PC_STEP);
                end else if (redirect) begin
                    // Delay slot not fetched yet: remember where to go afterwards.
                    pending_target_d = target;
                    state_d          = PENDING;
                end
            end
            PENDING: begin
                if (advance) begin
                    pc_d    = pending_target_q;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= RUN;
            pc_q             <= RESET_PC;
            pending_target_q <= '0;
            pc_req_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            pending_target_q <= pending_target_d;
            pc_req_q         <= 1'b1;
        end
    end

    assign pc_out           = pc_q;
    assign pc_req           = pc_req_q;
    assign redirect_pending = (state_q == PENDING);

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed self-checking bench for pc_ctrl: a queue-based fetch model is
// compared every cycle, and literal expectations pin the model itself.
module tb_pc_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        imem_ready;
    logic        id_fire;
    logic [31:0] id_pc;
    logic        is_branch;
    logic        branch_in;
    logic [15:0] branch_imm;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] pc_out;
    logic        pc_req;
    logic        redirect_pending;

    int n_checks = 0;
    int n_fail   = 0;

    pc_ctrl #(.RESET_PC(RESET_PC), .PC_STEP(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .imem_ready       (imem_ready),
        .id_fire          (id_fire),
        .id_pc            (id_pc),
        .is_branch        (is_branch),
        .branch_in        (branch_in),
        .branch_imm       (branch_imm),
        .jump             (jump),
        .jump_index       (jump_index),
        .jr               (jr),
        .jr_target        (jr_target),
        .pc_out           (pc_out),
        .pc_req           (pc_req),
        .redirect_pending (redirect_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a redirect queues its target (only one may be outstanding); each
    // fetched word moves the PC to the queued target if any, else to PC+4.
    logic [31:0] m_pc;
    bit          m_req;
    logic [31:0] m_q[$];

    function automatic logic [31:0] model_target();
        logic [31:0] seq;
        logic [31:0] off;
        seq = id_pc + 32'd4;
        off = 32'(signed'(branch_imm)) * 32'd4;
        if (jr)   return jr_target;
        if (jump) return {seq[31:28], jump_index, 2'b00};
        return seq + off;
    endfunction

    always @(posedge clk) begin
        bit redir;
        redir = id_fire && (jr || jump || (is_branch && branch_in));
        if (reset) begin
            m_pc  = RESET_PC;
            m_req = 1'b0;
            m_q.delete();
        end else begin
            if (redir && m_q.size() != 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL redirect_while_pending: got redirect, expected none at %0t", $time);
            end
            if (redir && m_q.size() == 0) m_q.push_back(model_target());
            if (m_req && imem_ready && !stall)
                m_pc = (m_q.size() != 0) ? m_q.pop_front() : m_pc + 32'd4;
            m_req = 1'b1;
        end
    end

    always @(negedge clk) begin
        check("model_pc_out", pc_out, m_pc);
        check("model_pc_req", {31'd0, pc_req}, {31'd0, m_req});
        check("model_pending", {31'd0, redirect_pending}, {31'd0, m_q.size() != 0});
    end

    task automatic idle();
        id_fire    = 1'b0;
        id_pc      = '0;
        is_branch  = 1'b0;
        branch_in  = 1'b0;
        branch_imm = '0;
        jump       = 1'b0;
        jump_index = '0;
        jr         = 1'b0;
        jr_target  = '0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic branch(input logic [31:0] pc, input logic [15:0] imm, input logic taken);
        idle();
        id_fire    = 1'b1;
        id_pc      = pc;
        is_branch  = 1'b1;
        branch_in  = taken;
        branch_imm = imm;
    endtask

    initial begin
        reset      = 1'b1;
        stall      = 1'b0;
        imem_ready = 1'b1;
        idle();
        cyc(2);
        check("reset_pc", pc_out, 32'h3000);
        check("reset_req", {31'd0, pc_req}, 32'd0);
        check("reset_pending", {31'd0, redirect_pending}, 32'd0);

        reset = 1'b0;
        cyc(1);
        check("req_rise", {31'd0, pc_req}, 32'd1);
        check("first_pc", pc_out, 32'h3000);
        cyc(1);
        check("seq_3004", pc_out, 32'h3004);
        cyc(1);
        check("seq_3008", pc_out, 32'h3008);

        // Zero-bubble taken branch.
        branch(32'h3004, 16'h0010, 1'b1);
        cyc(1);
        check("branch_fwd", pc_out, 32'h3048);
        check("branch_no_pend", {31'd0, redirect_pending}, 32'd0);

        // Return to 0x3008 via jr, then a branch while imem is not ready.
        idle();
        id_fire = 1'b1; id_pc = 32'h3044; jr = 1'b1; jr_target = 32'h3008;
        cyc(1);
        check("jr_back", pc_out, 32'h3008);
        branch(32'h3004, 16'h0010, 1'b1);
        imem_ready = 1'b0;
        cyc(1);
        idle();
        check("pend_hold_1", pc_out, 32'h3008);
        check("pend_set", {31'd0, redirect_pending}, 32'd1);
        cyc(2);
        check("pend_hold_3", pc_out, 32'h3008);
        check("pend_still", {31'd0, redirect_pending}, 32'd1);
        imem_ready = 1'b1;
        cyc(1);
        check("pend_release", pc_out, 32'h3048);
        check("pend_clear", {31'd0, redirect_pending}, 32'd0);

        // Stall with ready high also defers the redirect.
        stall = 1'b1;
        branch(32'h3044, 16'h0001, 1'b1);
        cyc(1);
        idle();
        stall = 1'b1; imem_ready = 1'b0;
        cyc(1);
        check("stall_hold", pc_out, 32'h3048);
        check("stall_pend", {31'd0, redirect_pending}, 32'd1);
        stall = 1'b0; imem_ready = 1'b1;
        cyc(1);
        check("stall_release", pc_out, 32'h304C);

        // Backward branch, then address wrap.
        branch(32'h3000, 16'hFFFF, 1'b1);
        cyc(1);
        check("branch_back", pc_out, 32'h3000);
        branch(32'hFFFF_FFFC, 16'h0001, 1'b1);
        cyc(1);
        check("branch_wrap", pc_out, 32'h0000_0004);

        // Not-taken branch and redirect without id_fire are sequential.
        branch(32'h0000_0000, 16'h0100, 1'b0);
        cyc(1);
        check("not_taken", pc_out, 32'h0000_0008);
        idle();
        jump = 1'b1; jump_index = 26'h0000C00;
        cyc(1);
        check("no_fire", pc_out, 32'h0000_000C);

        // jr beats jump beats branch.
        branch(32'h3010, 16'h0040, 1'b1);
        jump = 1'b1; jump_index = 26'h0000C00; jr = 1'b1; jr_target = 32'h0000_4180;
        cyc(1);
        check("jr_priority", pc_out, 32'h4180);
        branch(32'h3010, 16'h0040, 1'b1);
        jump = 1'b1; jump_index = 26'h0000C00;
        cyc(1);
        check("jump_only", pc_out, 32'h3000);

        // Reset while PENDING discards the latched target.
        idle();
        id_fire = 1'b1; id_pc = 32'h3000; jump = 1'b1; jump_index = 26'h0000C40;
        imem_ready = 1'b0;
        cyc(1);
        idle();
        check("pre_reset_pend", {31'd0, redirect_pending}, 32'd1);
        cyc(1);
        reset = 1'b1; imem_ready = 1'b1;
        cyc(1);
        check("rst_pend_pc", pc_out, 32'h3000);
        check("rst_pend_clear", {31'd0, redirect_pending}, 32'd0);
        reset = 1'b0;
        cyc(1);
        check("rst_resume_pc", pc_out, 32'h3000);
        cyc(1);
        check("rst_no_jump", pc_out, 32'h3004);
        cyc(1);
        check("rst_seq", pc_out, 32'h3008);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Fetch-stage program-counter controller that sits directly downstream of the ID-stage branch comparator.
- Each cycle it decides the next fetch address from: sequential PC+4, a taken conditional branch (comparator's branch_out), j/jal, or jr.
- Honours MIPS single delay-slot semantics, the hazard-unit stall, and a ready handshake from instruction memory.
- Latches a redirect that arrives while the delay-slot fetch is still outstanding.

Parameters:
RESET_PC, 32'h0000_3000, fetch address loaded on reset
PC_STEP, 4, byte increment for a sequential fetch

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
stall  in  1  hazard-unit freeze of IF/ID; 1 = PC must hold
imem_ready  in  1  instruction memory has returned the word at pc_out this cycle
id_fire  in  1  ID instruction is valid and leaves ID this cycle; redirect inputs are ignored when 0
id_pc  in  32  PC of the instruction currently in ID
is_branch  in  1  ID instruction is beq/bne/blez/bltz/bgez/bgtz
branch_in  in  1  branch_out from the comparator (taken)
branch_imm  in  16  imm16 field of the ID instruction
jump  in  1  ID instruction is j/jal
jump_index  in  26  instr_index field
jr  in  1  ID instruction is jr/jalr
jr_target  in  32  forwarded rs value
pc_out  out  32  current fetch address (registered)
pc_req  out  1  fetch request valid (registered)
redirect_pending  out  1  a latched redirect awaits completion of the delay-slot fetch

Behaviour:
- Reset is synchronous, active-high, and wins over everything:
  - pc_out <= RESET_PC; pc_req <= 0; state <= RUN; pending_target <= 0; redirect_pending = 0.
  - pc_req rises to 1 on the first clock edge after reset deasserts and stays 1 until the next reset.
- advance = pc_req & imem_ready & ~stall. This is the only condition under which the word at pc_out counts as fetched.
- redirect = id_fire & (jr | jump | (is_branch & branch_in)).
- Target selection, priority jr > jump > branch:
  - jr: jr_target, used unmodified (no alignment masking).
  - jump: {seq[31:28], jump_index, 2'b00}, where seq = id_pc + 4.
  - branch: seq + {{14{branch_imm[15]}}, branch_imm, 2'b00}, modulo 2^32 (wraps silently).
- Delay slot: when a redirect is valid, pc_out already addresses id_pc+4 (the delay slot). That word is always fetched before the PC moves to the target.
- Two-state FSM, RUN and PENDING; redirect_pending = (state == PENDING).
- RUN:
  - advance & redirect: pc_out <= target; stay RUN (zero-bubble redirect).
  - advance & ~redirect: pc_out <= pc_out + PC_STEP (wraps at 2^32).
  - ~advance & redirect: pending_target <= target; pc_out holds; go to PENDING.
  - ~advance & ~redirect: hold.
- PENDING:
  - advance: pc_out <= pending_target; go to RUN.
  - ~advance: hold pc_out and pending_target.
  - Any redirect seen in PENDING is ignored. This case is illegal, because the delay slot has not yet reached ID; the bench flags it with an assertion.
- stall and imem_ready low in the same cycle: treated as ~advance; no extra state.
- Reset asserted while in PENDING: the pending redirect is discarded and the block restarts at RESET_PC.
- Latency:
  - pc_out changes exactly one cycle after an advancing edge.
  - A latched redirect reaches pc_out one cycle after the delay-slot advance.
- Not-taken branch (is_branch & ~branch_in): treated as sequential.

Test Plan:
- Reset held 2 cycles, then released with imem_ready=1, stall=0 -> pc_out=0x3000 and pc_req=0 during reset; pc_req=1 next cycle; pc_out steps 0x3004, 0x3008 on successive cycles.
- pc_out=0x3008, id_fire=1, id_pc=0x3004, is_branch=1, branch_in=1, imm=0x0010, advance=1 -> next pc_out=0x3048; redirect_pending stays 0.
- Same branch but imem_ready=0 for 3 cycles -> pc_out holds 0x3008 and redirect_pending=1; on the cycle imem_ready=1, pc_out becomes 0x3048 next cycle and redirect_pending clears.
- id_pc=0x3000, imm=0xFFFF, taken, advancing -> pc_out=0x3000 (backward branch). Separately, id_pc=0xFFFFFFFC, imm=0x0001 -> pc_out=0x00000004 (wrap).
- jump=1 and jr=1 both asserted, id_pc=0x3010, jump_index=0x0000C00, jr_target=0x0000_4180 -> pc_out=0x4180 (jr priority). With jump alone -> pc_out=0x3000.
- Enter PENDING with pending_target=0x3100, then assert reset -> pc_out=0x3000, redirect_pending=0; after release, sequential fetch resumes with no jump to 0x3100.
